uart_tx_sb_ctrl: RTL and testbench
==================================

Name: uart_tx_sb_ctrl

Overview:
- System-bus responder peripheral that drives the board UART transmit pin `tx_o`.
- Sits on a system-bus slot like the other `*_sb_ctrl` peripherals. The core's LSU is the initiator.
- Decodes a small register map on `addr_i` and double-buffers one byte (holding register plus shifter).
- Serialises frames as 8N1/8E1/8N2/8E2 with a software-programmable bit divider, and raises an interrupt when the transmitter drains.

Parameters:
- CLK_HZ, 10_000_000, system clock frequency in Hz.
- DEFAULT_BAUD, 115200, baud rate selected after reset; default divider = CLK_HZ/DEFAULT_BAUD (86).
- DIV_W, 16, width of the bit-period divider register.

Ports:
- clk_i  in  1  system clock.
- resetn_i  in  1  asynchronous, active-low reset.
- req_i  in  1  bus request; this slot is selected.
- write_enable_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address; bits [23:0] are decoded, upper bits are already zeroed by the interconnect.
- write_data_i  in  32  write data.
- read_data_o  out  32  registered read data.
- interrupt_request_o  out  1  level interrupt to the core.
- interrupt_return_i  in  1  interrupt acknowledge pulse from the core.
- tx_o  out  1  UART serial output, idle high.

Behaviour:
- Reset (resetn_i=0, asynchronous):
  - tx_o=1, read_data_o=0, interrupt_request_o=0.
  - holding empty, shifter idle.
  - DIV=CLK_HZ/DEFAULT_BAUD, PARITY_EN=0, STOP2=0, IRQ_EN=0, irq_pend=0.
- Register map (addr_i[23:0]); addr_i[1:0]!=0 is ignored on write and reads 0:
  - 0x00 DATA, W: byte [7:0] loads the holding register. Accepted only if full=0 at the sampling edge; otherwise silently dropped (no stall). Reads return 0.
  - 0x04 STATUS, R: bit0 busy (shifter active), bit1 full (holding valid), bit2 irq_pend. Writes are ignored.
  - 0x08 DIV, RW [DIV_W-1:0]: clock cycles per bit. Written values <2 are stored as 2. Sampled by the shifter only at frame start.
  - 0x0C PARITY_EN, RW bit0: 1 = even parity bit after the data bits.
  - 0x10 STOP2, RW bit0: 1 = two stop bits.
  - 0x14 IRQ_EN, RW bit0.
  - 0x24 SOFT_RST, W: writing bit0=1 restores all reset values at the next edge (synchronous). Writing 0 has no effect.
  - Any other offset: write ignored, read returns 0.
- Bus timing:
  - Read: sampled when req_i=1, write_enable_i=0. read_data_o is valid on the cycle after the sampling edge and holds until the next read.
  - Write: takes effect at the sampling edge.
  - Interconnect treats this slot as always ready.
- Shifter FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_o=1. If full=1, load the shifter from holding, clear full, latch DIV/PARITY_EN/STOP2, go to START.
    - Write sampled at edge E0 → full=1 after E0 → tx_o=0 after E1.
  - START: tx_o=0 for DIV cycles.
  - DATA: bits 0..7, LSB first, DIV cycles each.
  - PARITY: entered only if latched PARITY_EN=1. tx_o = XOR of the 8 data bits. DIV cycles.
  - STOP: tx_o=1 for DIV cycles, or 2·DIV cycles if latched STOP2=1.
  - End of STOP: if full=1, go directly to START with no idle gap (back-to-back). Otherwise go to IDLE.
  - Frame length = DIV·(10 + PARITY_EN + STOP2) cycles.
  - busy = (state != IDLE).
- Counters:
  - Bit-period counter counts 0..DIV-1 and wraps.
  - Bit index counter 0..7.
- Interrupt:
  - irq_pend sets at the edge that ends STOP when full=0.
  - irq_pend clears on interrupt_return_i=1, on any accepted DATA write, or on SOFT_RST.
  - Set and clear in the same cycle: clear wins.
  - interrupt_request_o = IRQ_EN & irq_pend (registered).
- Reset or SOFT_RST mid-frame: the frame is truncated, tx_o returns to 1, and the holding contents are discarded.
- Config writes while busy do not alter the frame in progress.

Decomposition:
- Package uart_sb_pkg holds:
  - register offset localparams (ADDR_DATA, ADDR_STATUS, ADDR_DIV, ADDR_PARITY, ADDR_STOP2, ADDR_IRQ_EN, ADDR_SRST);
  - tx FSM state enum uart_tx_state_t;
  - STATUS bit index constants.
- Sub-module uart_tx_core contains the shifter FSM, baud counter and parity. Its interface is a valid/ready byte input, cfg inputs latched at start, busy, done pulse and tx.
- uart_tx_sb_ctrl contains the bus decode, config registers, holding register and irq logic.

Test Plan:
- Default config (DIV=86), write DATA=0x55 → tx_o low after E1. Bits 0,1,0,1,0,1,0,1,0,1 at 86 cycles each. Idle high after 860 cycles. STATUS reads 0x1 mid-frame and 0x0 after.
- PARITY_EN=1, STOP2=1, DIV=4, write 0x07 → start bit, bits 1,1,1,0,0,0,0,0, parity 1, stop 1,1 (48 cycles total).
- DIV=4; write 0xA1, 0xB2, 0xC3 on consecutive cycles → 0xA1 then 0xB2 sent with no idle gap. 0xC3 dropped. STATUS reads 0x3 between writes 2 and 3.
- IRQ_EN=1; send 0x33 → interrupt_request_o=1 one cycle after frame end. Pulse interrupt_return_i → 0 next cycle. STATUS bit2 tracks irq_pend.
- Write DIV=1 → readback 2. Read 0x18 → 0. Read addr 0x02 → 0. Write DIV=8 mid-frame at DIV=4 → current frame bits stay 4 cycles, next frame uses 8.
- resetn_i low for 3 cycles during DATA bit 3 → tx_o=1 immediately, STATUS=0, DIV reads 86. SOFT_RST write mid-frame → same result at the next edge.

Source files
------------

// File: rtl/uart_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_sb_pkg
// Brief    : Register map, tx FSM states and STATUS bit positions.
// Revision : 1.0
// ============================================================================
package uart_sb_pkg;

    localparam logic [23:0] ADDR_DATA   = 24'h00_0000;
    localparam logic [23:0] ADDR_STATUS = 24'h00_0004;
    localparam logic [23:0] ADDR_DIV    = 24'h00_0008;
    localparam logic [23:0] ADDR_PARITY = 24'h00_000C;
    localparam logic [23:0] ADDR_STOP2  = 24'h00_0010;
    localparam logic [23:0] ADDR_IRQ_EN = 24'h00_0014;
    localparam logic [23:0] ADDR_SRST   = 24'h00_0024;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_IRQ  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_core
// Brief    : UART shifter FSM with bit-period counter and even parity.
// Revision : 1.0
// ============================================================================
module uart_tx_core
    import uart_sb_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_parity_i,
    input  logic             cfg_stop2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             tx_o
);

    uart_tx_state_t   state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             par_en_q, par_en_d;
    logic             stop2_q, stop2_d;

    logic w_bit_end;
    logic w_stop_end;
    logic w_accept;

    assign w_bit_end  = (cnt_q == div_q - DIV_W'(1));
    // bit_q counts stop bits too: 0 = first, 1 = second
    assign w_stop_end = (state_q == ST_STOP) & w_bit_end & (bit_q[0] == stop2_q);
    assign in_ready_o = (state_q == ST_IDLE) | w_stop_end;
    assign w_accept   = in_valid_i & in_ready_o;
    assign done_o     = w_stop_end & ~in_valid_i;
    assign busy_o     = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        div_d    = div_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        if (state_q != ST_IDLE) begin
            cnt_d = w_bit_end ? '0 : cnt_q + DIV_W'(1);
        end
        case (state_q)
            ST_START: if (w_bit_end) begin
                state_d = ST_DATA;
                bit_d   = 3'd0;
            end
            ST_DATA: if (w_bit_end) begin
                shreg_d = {1'b1, shreg_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (w_bit_end) begin
                state_d = ST_STOP;
            end
            ST_STOP: if (w_bit_end) begin
                if (w_stop_end) begin
                    state_d = ST_IDLE;
                end else begin
                    bit_d = 3'd1;
                end
            end
            default: ;
        endcase
        // Accepting at the end of STOP chains frames with no idle gap
        if (w_accept) begin
            state_d  = ST_START;
            cnt_d    = '0;
            bit_d    = 3'd0;
            shreg_d  = in_data_i;
            par_d    = ^in_data_i;
            div_d    = cfg_div_i;
            par_en_d = cfg_parity_i;
            stop2_d  = cfg_stop2_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_W'(2);
            bit_q    <= 3'd0;
            shreg_q  <= 8'h00;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else if (clear_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_W'(2);
            bit_q    <= 3'd0;
            shreg_q  <= 8'h00;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
        end
    end

    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            ST_START:  tx_o = 1'b0;
            ST_DATA:   tx_o = shreg_q[0];
            ST_PARITY: tx_o = par_q;
            default:   tx_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sb_ctrl
// Brief    : System-bus UART transmitter: register decode, holding byte, IRQ.
// Revision : 1.0
// ============================================================================
module uart_tx_sb_ctrl
    import uart_sb_pkg::*;
#(
    parameter int CLK_HZ       = 10_000_000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int DIV_W        = 16
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        interrupt_request_o,
    input  logic        interrupt_return_i,
    output logic        tx_o
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_HZ / DEFAULT_BAUD);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    logic [DIV_W-1:0] div_q, div_d;
    logic             par_en_q, par_en_d;
    logic             stop2_q, stop2_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_pend_q, irq_pend_d;
    logic             irq_q, irq_d;
    logic             full_q, full_d;
    logic [7:0]       hold_q, hold_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [23:0] w_off;
    logic        w_wr, w_rd, w_srst, w_data_wr, w_take;
    logic        w_core_ready, w_busy, w_done;
    logic        w_unused;

    // Misaligned offsets never match a register constant, so they decode to nothing
    assign w_off     = addr_i[23:0];
    assign w_wr      = req_i & write_enable_i;
    assign w_rd      = req_i & ~write_enable_i;
    assign w_srst    = w_wr & (w_off == ADDR_SRST) & write_data_i[0];
    assign w_data_wr = w_wr & (w_off == ADDR_DATA) & ~full_q;
    assign w_take    = full_q & w_core_ready;
    assign w_unused  = ^{addr_i[31:24], write_data_i};

    always_comb begin
        div_d      = div_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        irq_en_d   = irq_en_q;
        full_d     = full_q;
        hold_d     = hold_q;
        rdata_d    = rdata_q;
        irq_pend_d = irq_pend_q;
        irq_d      = irq_en_q & irq_pend_q;
        if (w_wr) begin
            case (w_off)
                ADDR_DIV:    div_d = (write_data_i[DIV_W-1:0] < DIV_MIN) ?
                                     DIV_MIN : write_data_i[DIV_W-1:0];
                ADDR_PARITY: par_en_d = write_data_i[0];
                ADDR_STOP2:  stop2_d  = write_data_i[0];
                ADDR_IRQ_EN: irq_en_d = write_data_i[0];
                default: ;
            endcase
        end
        if (w_data_wr) begin
            full_d = 1'b1;
            hold_d = write_data_i[7:0];
        end else if (w_take) begin
            full_d = 1'b0;
        end
        if (interrupt_return_i | w_data_wr) begin
            irq_pend_d = 1'b0;
        end else if (w_done) begin
            irq_pend_d = 1'b1;
        end
        if (w_rd) begin
            rdata_d = 32'h0;
            case (w_off)
                ADDR_STATUS: begin
                    rdata_d[STAT_BUSY] = w_busy;
                    rdata_d[STAT_FULL] = full_q;
                    rdata_d[STAT_IRQ]  = irq_pend_q;
                end
                ADDR_DIV:    rdata_d[DIV_W-1:0] = div_q;
                ADDR_PARITY: rdata_d[0] = par_en_q;
                ADDR_STOP2:  rdata_d[0] = stop2_q;
                ADDR_IRQ_EN: rdata_d[0] = irq_en_q;
                default: ;
            endcase
        end
        if (w_srst) begin
            div_d      = DIV_RST;
            par_en_d   = 1'b0;
            stop2_d    = 1'b0;
            irq_en_d   = 1'b0;
            irq_pend_d = 1'b0;
            irq_d      = 1'b0;
            full_d     = 1'b0;
            hold_d     = 8'h00;
            rdata_d    = 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            div_q      <= DIV_RST;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_q      <= 1'b0;
            full_q     <= 1'b0;
            hold_q     <= 8'h00;
            rdata_q    <= 32'h0;
        end else begin
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            irq_q      <= irq_d;
            full_q     <= full_d;
            hold_q     <= hold_d;
            rdata_q    <= rdata_d;
        end
    end

    assign read_data_o         = rdata_q;
    assign interrupt_request_o = irq_q;

    uart_tx_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .clear_i      (w_srst),
        .in_valid_i   (full_q),
        .in_data_i    (hold_q),
        .in_ready_o   (w_core_ready),
        .cfg_div_i    (div_q),
        .cfg_parity_i (par_en_q),
        .cfg_stop2_i  (stop2_q),
        .busy_o       (w_busy),
        .done_o       (w_done),
        .tx_o         (tx_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sb_ctrl
// Brief    : Directed, table-driven bench for uart_tx_sb_ctrl.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_sb_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        irq_ret = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;
    logic        tx;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          frame_t0 = 0;
    int          w_neg = 0;
    int          t0a = 0;
    logic [31:0] rd;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sb_ctrl dut (
        .clk_i               (clk),
        .resetn_i            (resetn),
        .req_i               (req),
        .write_enable_i      (we),
        .addr_i              (addr),
        .write_data_i        (wdata),
        .read_data_o         (rdata),
        .interrupt_request_o (irq),
        .interrupt_return_i  (irq_ret),
        .tx_o                (tx)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the sampling edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        d = rdata;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_idle(input int n, input string nm);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad = 1'b1;
        end
        chk(nm, {31'b0, bad}, 32'h0);
    endtask

    // Waits for a start bit, then samples every bit at its midpoint
    task automatic check_frame(input logic [7:0] b, input int div, input logic par,
                               input logic st2, input string nm);
        logic [11:0] expv, obs;
        int nb, n;
        expv = '1;
        obs  = '1;
        expv[0]   = 1'b0;
        expv[8:1] = b;
        if (par) expv[9] = ^b;
        nb = 10 + int'(par) + int'(st2);
        n  = 0;
        while (tx !== 1'b0) begin
            if (n >= 4000) begin
                chk({nm, "_start_timeout"}, 32'h1, 32'h0);
                return;
            end
            @(negedge clk);
            n++;
        end
        frame_t0 = cyc;
        for (int k = 0; k < nb; k++) begin
            wait_until(frame_t0 + k * div + div / 2);
            obs[k] = tx;
        end
        chk(nm, {20'b0, obs}, {20'b0, expv});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = {1'b0, 32'h08, 32'd86};
        vecs[1]  = {1'b0, 32'h0C, 32'd0};
        vecs[2]  = {1'b0, 32'h10, 32'd0};
        vecs[3]  = {1'b0, 32'h14, 32'd0};
        vecs[4]  = {1'b1, 32'h08, 32'd1};
        vecs[5]  = {1'b0, 32'h08, 32'd2};
        vecs[6]  = {1'b1, 32'h08, 32'd0};
        vecs[7]  = {1'b0, 32'h08, 32'd2};
        vecs[8]  = {1'b1, 32'h08, 32'hFFFF_0005};
        vecs[9]  = {1'b0, 32'h08, 32'd5};
        vecs[10] = {1'b0, 32'h18, 32'd0};
        vecs[11] = {1'b0, 32'h02, 32'd0};
        vecs[12] = {1'b1, 32'h0A, 32'd9};
        vecs[13] = {1'b0, 32'h08, 32'd5};
        vecs[14] = {1'b0, 32'h0A, 32'd0};
        vecs[15] = {1'b1, 32'h0C, 32'd3};
        vecs[16] = {1'b0, 32'h0C, 32'd1};
        vecs[17] = {1'b1, 32'h04, 32'd7};
        vecs[18] = {1'b0, 32'h04, 32'd0};
        vecs[19] = {1'b1, 32'h10, 32'd1};
        vecs[20] = {1'b0, 32'h10, 32'd1};
        vecs[21] = {1'b1, 32'h14, 32'd1};
        vecs[22] = {1'b0, 32'h14, 32'd1};
        vecs[23] = {1'b0, 32'h00, 32'd0};
        vecs[24] = {1'b0, 32'h24, 32'd0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'h1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Register map
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                chk($sformatf("reg_vec%0d", i), rd, vecs[i].data);
            end
        end
        bus_write(32'h0C, 32'd0);
        bus_write(32'h10, 32'd0);
        bus_write(32'h14, 32'd0);
        bus_write(32'h08, 32'd86);

        // Default 8N1 frame, DIV=86
        bus_write(32'h00, 32'h55);
        w_neg = cyc;
        chk("pre_start_tx", {31'b0, tx}, 32'h1);
        fork
            check_frame(8'h55, 86, 1'b0, 1'b0, "frame_55");
            begin
                repeat (300) @(negedge clk);
                bus_read(32'h04, rd);
                chk("status_busy", rd, 32'h1);
            end
        join
        chk("start_latency", 32'(frame_t0 - w_neg), 32'd1);
        wait_until(frame_t0 + 862);
        bus_read(32'h04, rd);
        chk("status_idle", rd & 32'h3, 32'h0);
        chk("idle_tx", {31'b0, tx}, 32'h1);

        // 8E2 at DIV=4
        bus_write(32'h08, 32'd4);
        bus_write(32'h0C, 32'd1);
        bus_write(32'h10, 32'd1);
        bus_write(32'h00, 32'h07);
        check_frame(8'h07, 4, 1'b1, 1'b1, "frame_8e2");

        // Back-to-back with a dropped third write
        bus_write(32'h0C, 32'd0);
        bus_write(32'h10, 32'd0);
        fork
            begin
                check_frame(8'hA1, 4, 1'b0, 1'b0, "b2b_a1");
                t0a = frame_t0;
                check_frame(8'hB2, 4, 1'b0, 1'b0, "b2b_b2");
                chk("b2b_gap", 32'(frame_t0 - t0a), 32'd40);
                expect_idle(60, "c3_dropped");
            end
            begin
                bus_write(32'h00, 32'hA1);
                @(negedge clk);
                bus_write(32'h00, 32'hB2);
                bus_read(32'h04, rd);
                chk("status_full", rd, 32'h3);
                bus_write(32'h00, 32'hC3);
            end
        join

        // Interrupt
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ret = 1'b0;
        bus_write(32'h14, 32'd1);
        repeat (2) @(negedge clk);
        chk("irq_quiet", {31'b0, irq}, 32'h0);
        bus_write(32'h00, 32'h33);
        check_frame(8'h33, 4, 1'b0, 1'b0, "frame_33");
        wait_until(frame_t0 + 40);
        chk("irq_not_yet", {31'b0, irq}, 32'h0);
        wait_until(frame_t0 + 41);
        chk("irq_raise", {31'b0, irq}, 32'h1);
        bus_read(32'h04, rd);
        chk("status_irq", rd, 32'h4);
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ret = 1'b0;
        @(negedge clk);
        chk("irq_clear", {31'b0, irq}, 32'h0);
        bus_read(32'h04, rd);
        chk("status_irq_clr", rd, 32'h0);

        // DIV rewrite mid-frame only affects the next frame
        bus_write(32'h00, 32'h5A);
        fork
            check_frame(8'h5A, 4, 1'b0, 1'b0, "frame_div4");
            begin
                repeat (8) @(negedge clk);
                bus_write(32'h08, 32'd8);
            end
        join
        bus_read(32'h08, rd);
        chk("div_rb8", rd, 32'd8);
        bus_write(32'h00, 32'h3C);
        check_frame(8'h3C, 8, 1'b0, 1'b0, "frame_div8");

        // Asynchronous reset during data bit 3, holding register full
        bus_write(32'h00, 32'hF7);
        w_neg = cyc;
        @(negedge clk);
        bus_write(32'h00, 32'h81);
        bus_read(32'h04, rd);
        chk("arst_full", rd, 32'h3);
        wait_until(w_neg + 1 + 4 * 8 + 4);
        chk("arst_bit3", {31'b0, tx}, 32'h0);
        resetn = 1'b0;
        #1;
        chk("arst_tx_now", {31'b0, tx}, 32'h1);
        chk("arst_rdata", rdata, 32'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        bus_read(32'h04, rd);
        chk("arst_status", rd, 32'h0);
        bus_read(32'h08, rd);
        chk("arst_div", rd, 32'd86);
        expect_idle(40, "arst_discard");

        // Soft reset during data bit 3, holding register full
        bus_write(32'h08, 32'd4);
        bus_write(32'h00, 32'hF7);
        w_neg = cyc;
        @(negedge clk);
        bus_write(32'h00, 32'h81);
        bus_read(32'h04, rd);
        chk("srst_full", rd, 32'h3);
        wait_until(w_neg + 1 + 4 * 4 + 2);
        chk("srst_bit3", {31'b0, tx}, 32'h0);
        bus_write(32'h24, 32'h1);
        chk("srst_tx", {31'b0, tx}, 32'h1);
        bus_read(32'h04, rd);
        chk("srst_status", rd, 32'h0);
        bus_read(32'h08, rd);
        chk("srst_div", rd, 32'd86);
        expect_idle(40, "srst_discard");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
